// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin burst scheduler sharing one AXI4 read master between two line-buffer FIFOs.
// Define AXI_RD_ARB_TIMEOUT_EN to add a sticky rd_timeout watchdog for bursts that never complete.
module axi_rd_arbiter #(
    parameter int          AXI_WIDTH      = 256,
    parameter logic [7:0]  BURST_LEN      = 8'd31,
    parameter int          FIFO_DEPTH     = 512,
    parameter logic [28:0] CH0_BASE       = 29'h000_0000,
    parameter logic [28:0] CH1_BASE       = 29'h080_0000,
    parameter logic [28:0] FRAME_BYTES    = 29'h1C_2000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ch0_en,
    input  logic                 ch1_en,
    input  logic                 ch0_frame_rst,
    input  logic                 ch1_frame_rst,
    input  logic [9:0]           ch0_fifo_cnt,
    input  logic [9:0]           ch1_fifo_cnt,
    output logic                 ch0_wr_en,
    output logic                 ch1_wr_en,
    output logic [AXI_WIDTH-1:0] ch_wr_data,
`ifdef AXI_RD_ARB_TIMEOUT_EN
    output logic                 rd_timeout,
`endif
    output logic                 rd_start,
    output logic [28:0]          rd_addr,
    output logic [7:0]           rd_len,
    input  logic                 rd_ready,
    input  logic                 rd_done,
    input  logic [AXI_WIDTH-1:0] rd_data,
    input  logic                 r_handshake
);
    localparam logic [28:0] BURST_BYTES = 29'((32'(BURST_LEN) + 1) * AXI_WIDTH / 8);
    localparam logic [28:0] END0 = CH0_BASE + FRAME_BYTES;
    localparam logic [28:0] END1 = CH1_BASE + FRAME_BYTES;
    localparam logic [10:0] DEPTH = 11'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t      state;
    logic        grant, ptr, pend0, pend1;
    logic [28:0] addr0, addr1;

    logic req0, req1, pick, fly0, fly1;
    logic [28:0] sum0, sum1, nxt0, nxt1, la0, la1;

    assign req0 = ch0_en && (11'(ch0_fifo_cnt) + 11'(BURST_LEN) + 11'd1 <= DEPTH);
    assign req1 = ch1_en && (11'(ch1_fifo_cnt) + 11'(BURST_LEN) + 11'd1 <= DEPTH);
    assign pick = req1 && (!req0 || ptr);
    assign fly0 = state != IDLE && !grant;
    assign fly1 = state != IDLE && grant;
    assign sum0 = addr0 + BURST_BYTES;
    assign sum1 = addr1 + BURST_BYTES;
    // A restart requested during or at the end of a burst replaces the increment.
    assign nxt0 = (pend0 || ch0_frame_rst || sum0 == END0) ? CH0_BASE : sum0;
    assign nxt1 = (pend1 || ch1_frame_rst || sum1 == END1) ? CH1_BASE : sum1;
    assign la0  = ch0_frame_rst ? CH0_BASE : addr0;
    assign la1  = ch1_frame_rst ? CH1_BASE : addr1;

    assign rd_len     = BURST_LEN;
    assign ch_wr_data = rd_data;
    assign ch0_wr_en  = r_handshake && state == BUSY && !grant;
    assign ch1_wr_en  = r_handshake && state == BUSY && grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            ptr      <= 1'b0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            addr0    <= CH0_BASE;
            addr1    <= CH1_BASE;
            rd_start <= 1'b0;
            rd_addr  <= '0;
        end else begin
            if (ch0_frame_rst) begin
                if (fly0) pend0 <= 1'b1;
                else addr0 <= CH0_BASE;
            end
            if (ch1_frame_rst) begin
                if (fly1) pend1 <= 1'b1;
                else addr1 <= CH1_BASE;
            end
            case (state)
                IDLE: if (rd_ready && (req0 || req1)) begin
                    grant    <= pick;
                    rd_addr  <= pick ? la1 : la0;
                    rd_start <= 1'b1;
                    state    <= START;
                end
                START: begin
                    rd_start <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: if (rd_done) begin
                    if (grant) begin
                        addr1 <= nxt1;
                        pend1 <= 1'b0;
                    end else begin
                        addr0 <= nxt0;
                        pend0 <= 1'b0;
                    end
                    ptr   <= ~ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_RD_ARB_TIMEOUT_EN
    logic [15:0] tcnt;

    // The burst cannot be aborted, so the watchdog only flags; the FSM keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt       <= '0;
            rd_timeout <= 1'b0;
        end else if (state == START) begin
            tcnt <= '0;
        end else if (state == BUSY && !rd_done) begin
            if (tcnt != TIMEOUT_CYCLES) tcnt <= tcnt + 16'd1;
            if (tcnt == TIMEOUT_CYCLES - 16'd1) rd_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: stimulus queues expected bursts; a monitor pops them on rd_start and checks every
// routed beat against the channel of the burst in flight. Frame is shrunk to 0x1000 to reach the wrap quickly.
module tb_axi_rd_arbiter;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         ch0_en = 1'b0, ch1_en = 1'b0, ch0_frame_rst = 1'b0, ch1_frame_rst = 1'b0;
    logic [9:0]   ch0_fifo_cnt = '0, ch1_fifo_cnt = '0;
    logic         ch0_wr_en, ch1_wr_en, rd_start;
    logic [255:0] ch_wr_data, rd_data = '0;
    logic [28:0]  rd_addr;
    logic [7:0]   rd_len;
    logic         rd_ready = 1'b1, r_handshake = 1'b0, m_done = 1'b0, s_done = 1'b0, hold = 1'b0;
    logic         rd_done;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    logic         rd_timeout;
`endif

    int vecs = 0, errs = 0;
    int beats, cyc;
    logic owed, cur_ch = 1'b0, last_start = 1'b0;
    logic [29:0] exp_q[$];
    logic [29:0] e;

    assign rd_done = m_done | s_done;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.FRAME_BYTES(29'h1000), .TIMEOUT_CYCLES(16'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_en(ch0_en), .ch1_en(ch1_en),
        .ch0_frame_rst(ch0_frame_rst), .ch1_frame_rst(ch1_frame_rst),
        .ch0_fifo_cnt(ch0_fifo_cnt), .ch1_fifo_cnt(ch1_fifo_cnt),
        .ch0_wr_en(ch0_wr_en), .ch1_wr_en(ch1_wr_en), .ch_wr_data(ch_wr_data),
`ifdef AXI_RD_ARB_TIMEOUT_EN
        .rd_timeout(rd_timeout),
`endif
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ready(rd_ready), .rd_done(rd_done), .rd_data(rd_data), .r_handshake(r_handshake)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic ch, input logic [28:0] a);
        exp_q.push_back({ch, a});
    endtask

    task automatic wait_q(input string name, input int n);
        int t = 0;
        while (exp_q.size() > n && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() > n) begin
            vecs++;
            errs++;
            $display("FAIL %s: %0d bursts still outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) ch0_frame_rst = 1'b1;
        else if (which == 1) ch1_frame_rst = 1'b1;
        else s_done = 1'b1;
        @(negedge clk);
        ch0_frame_rst = 1'b0;
        ch1_frame_rst = 1'b0;
        s_done = 1'b0;
    endtask

    // Read-master model: 32 beats with periodic gaps, rd_done on the last beat unless held.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && rd_start) begin
            rd_ready = 1'b0;
            beats = 0;
            cyc = 0;
            owed = 1'b0;
            while (beats < 32 && rst_n) begin
                @(posedge clk);
                #1;
                r_handshake = 1'b0;
                m_done = 1'b0;
                cyc = cyc + 1;
                if (rst_n && cyc % 5 != 2) begin
                    r_handshake = 1'b1;
                    rd_data = {8{$urandom()}};
                    beats = beats + 1;
                    m_done = beats == 32 && !hold;
                    owed = beats == 32 && hold;
                end
            end
            @(posedge clk);
            #1;
            r_handshake = 1'b0;
            m_done = 1'b0;
            if (owed) begin
                while (hold && rst_n) begin
                    @(posedge clk);
                    #1;
                end
                if (rst_n) begin
                    m_done = 1'b1;
                    @(posedge clk);
                    #1;
                    m_done = 1'b0;
                end
            end
            rd_ready = 1'b1;
        end
    end

    // Monitor: compares burst requests against the queue and routed beats against the granted channel.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (rd_start) begin
                chk("rd_start_one_cycle", last_start, 1'b0);
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_rd_start: rd_addr %0h, none expected", rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    cur_ch = e[29];
                    chk("rd_addr", rd_addr, e[28:0]);
                    chk("rd_len", rd_len, 8'd31);
                end
            end
            chk("wr_en", {ch1_wr_en, ch0_wr_en}, r_handshake ? (cur_ch ? 2'b10 : 2'b01) : 2'b00);
            if (r_handshake) chk("wr_data", ch_wr_data, rd_data);
        end
        last_start = rd_start && rst_n;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rd_start", rd_start, 1'b0);
        chk("reset_rd_addr", rd_addr, 29'h0);
        chk("reset_rd_len", rd_len, 8'd31);
        chk("reset_wr_en", {ch1_wr_en, ch0_wr_en}, 2'b00);
`ifdef AXI_RD_ARB_TIMEOUT_EN
        chk("reset_rd_timeout", rd_timeout, 1'b0);
`endif
        rst_n = 1'b1;

        push(0, 29'h0); push(1, 29'h800000); push(0, 29'h400); push(1, 29'h800400);
        ch0_en = 1'b1;
        ch1_en = 1'b1;
        @(posedge clk);
        #1;
        chk("start_latency", rd_start, 1'b1);
        wait_q("alternate", 0);
        ch0_en = 1'b0;
        ch1_en = 1'b0;
        repeat (60) @(negedge clk);

        push(0, 29'h800); push(0, 29'hC00); push(0, 29'h0); push(0, 29'h400); push(0, 29'h800);
        ch0_en = 1'b1;
        wait_q("ch0_only_wrap", 0);
        ch0_en = 1'b0;
        repeat (60) @(negedge clk);

        ch0_fifo_cnt = 10'd481;
        ch0_en = 1'b1;
        repeat (60) @(negedge clk);
        ch0_fifo_cnt = 10'd1023;
        repeat (60) @(negedge clk);
        push(0, 29'hC00);
        ch0_fifo_cnt = 10'd480;
        wait_q("fifo_480", 0);
        ch0_fifo_cnt = 10'd1023;
        repeat (60) @(negedge clk);
        ch0_en = 1'b0;
        ch0_fifo_cnt = 10'd0;

        push(0, 29'h0);
        ch0_en = 1'b1;
        wait_q("after_wrap", 0);
        ch0_en = 1'b0;
        repeat (60) @(negedge clk);
        pulse(2);
        repeat (5) @(negedge clk);
        push(0, 29'h400);
        ch0_en = 1'b1;
        wait_q("stray_done", 0);
        ch0_en = 1'b0;
        repeat (60) @(negedge clk);
        pulse(0);
        push(0, 29'h0);
        ch0_en = 1'b1;
        wait_q("idle_frame_rst", 0);
        ch0_en = 1'b0;
        repeat (60) @(negedge clk);

        push(1, 29'h800800); push(1, 29'h800000);
        ch1_en = 1'b1;
        wait_q("ch1_first", 1);
        repeat (5) @(negedge clk);
        pulse(1);
        wait_q("ch1_after_rst", 0);
        ch1_en = 1'b0;
        repeat (60) @(negedge clk);

        push(0, 29'h400);
        ch0_en = 1'b1;
        wait_q("pre_reset", 0);
        ch0_en = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rd_start", rd_start, 1'b0);
        chk("midreset_rd_addr", rd_addr, 29'h0);
        chk("midreset_wr_en", {ch1_wr_en, ch0_wr_en}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        push(0, 29'h0); push(1, 29'h800000);
        ch0_en = 1'b1;
        ch1_en = 1'b1;
        wait_q("post_reset", 0);
        ch0_en = 1'b0;
        ch1_en = 1'b0;
        repeat (60) @(negedge clk);

`ifdef AXI_RD_ARB_TIMEOUT_EN
        hold = 1'b1;
        push(0, 29'h400);
        ch0_en = 1'b1;
        wait_q("timeout_burst", 0);
        ch0_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("timeout_before", rd_timeout, 1'b0);
        @(posedge clk);
        #1;
        chk("timeout_set", rd_timeout, 1'b1);
        hold = 1'b0;
        repeat (50) @(negedge clk);
        chk("timeout_sticky", rd_timeout, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
